elevator_call_latch: RTL and testbench

Request-capture stage directly upstream of the 4-floor elevator motor controller. Synchronizes raw hall-call and cab-call buttons, latches each press as a pending request, and clears a floor's requests only after the car has been stopped at that floor for a full door-dwell interval. Its outputs drive the controller's U/D/F request inputs. It also reports whether the floor sensors are consistent.

---
 rtl/elevator_pkg.sv | 27 ++
 rtl/btn_sync_edge.sv | 32 +++
 rtl/elevator_call_latch.sv | 168 ++++++++++++++++
 tb/tb_elevator_call_latch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request path and motor controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package elevator_pkg;

   localparam int NUM_FLOORS = 4;

   typedef logic [1:0] floor_t;

   // ST_ prefix keeps the state names clear of the DWELL parameter on the latch
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } dwell_state_t;

   // No up-call exists at the top floor, no down-call at the bottom floor
   localparam logic [NUM_FLOORS-1:0] HALL_UP_MASK = 4'b0111;
   localparam logic [NUM_FLOORS-1:0] HALL_DN_MASK = 4'b1110;

   // One-hot request mask selecting a single floor
   function automatic logic [NUM_FLOORS-1:0] floor_mask(input floor_t f);
      floor_mask = 4'b0001 << f;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Per-bit 2-flop synchronizer plus history flop; emits a one-cycle pulse per rising edge.
// Latency: raw sampled high at edge N gives a pulse in the cycle after edge N+1.
// Backpressure: none; a held input yields a single pulse.
module btn_sync_edge #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_rise
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_hist;

   // Two synchronizer stages, then one history stage for edge detection
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_hist <= '0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_hist;

endmodule

// File: rtl/elevator_call_latch.sv
// Latches hall/cab button presses and clears a floor's calls after a full stopped dwell.
// Latency: press sampled at edge N -> request after edge N+2; clear DWELL+1 edges after stop.
// Backpressure: none; a press coinciding with a clear of the same bit keeps it pending.
module elevator_call_latch #(
   parameter int DWELL = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] hall_up_raw,
   input  logic [3:0] hall_dn_raw,
   input  logic [3:0] cab_raw,
   input  logic [3:0] sensor,
   input  logic       stopped,
   output logic [3:0] req_up,
   output logic [3:0] req_dn,
   output logic [3:0] req_cab,
   output logic       pending,
   output logic       door_hold,
   output logic       sensor_fault
);
   import elevator_pkg::*;

   localparam int            CW      = $clog2(DWELL + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [11:0]           w_rise;
   logic [NUM_FLOORS-1:0] w_set_up;
   logic [NUM_FLOORS-1:0] w_set_dn;
   logic [NUM_FLOORS-1:0] w_set_cab;
   logic [NUM_FLOORS-1:0] w_clr;

   logic [NUM_FLOORS-1:0] r_req_up;
   logic [NUM_FLOORS-1:0] r_req_dn;
   logic [NUM_FLOORS-1:0] r_req_cab;

   floor_t                r_cur_floor;
   logic                  r_floor_valid;
   logic                  r_sensor_fault;

   dwell_state_t          r_state;
   dwell_state_t          w_state_nx;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nx;
   floor_t                r_dwell_floor;
   floor_t                w_dwell_floor_nx;
   logic                  w_stop_valid;
   logic                  w_here;
   logic                  w_clear;

   btn_sync_edge #(
      .WIDTH (12)
   ) u_sync (
      .clk     (clk),
      .i_rst_n (reset),
      .i_raw   ({cab_raw, hall_dn_raw, hall_up_raw}),
      .o_rise  (w_rise)
   );

   assign w_set_up  = w_rise[3:0] & HALL_UP_MASK;
   assign w_set_dn  = w_rise[7:4] & HALL_DN_MASK;
   assign w_set_cab = w_rise[11:8];

   // Register the floor position; zero sensors keeps the last floor, several flag a fault
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cur_floor    <= '0;
         r_floor_valid  <= 1'b0;
         r_sensor_fault <= 1'b0;
      end else begin
         case (sensor)
            4'b0001: begin r_cur_floor <= 2'd0; r_floor_valid <= 1'b1; r_sensor_fault <= 1'b0; end
            4'b0010: begin r_cur_floor <= 2'd1; r_floor_valid <= 1'b1; r_sensor_fault <= 1'b0; end
            4'b0100: begin r_cur_floor <= 2'd2; r_floor_valid <= 1'b1; r_sensor_fault <= 1'b0; end
            4'b1000: begin r_cur_floor <= 2'd3; r_floor_valid <= 1'b1; r_sensor_fault <= 1'b0; end
            default: begin
               r_floor_valid  <= 1'b0;
               r_sensor_fault <= (sensor != 4'b0000);
            end
         endcase
      end
   end

   assign w_stop_valid = stopped & r_floor_valid;
   assign w_here       = w_stop_valid & (r_cur_floor == r_dwell_floor);

   // Dwell FSM state, counter and captured floor
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_dwell_floor <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_dwell_floor <= w_dwell_floor_nx;
      end
   end

   // Next-state: count stopped cycles at one floor, clear once, then hold until the car leaves
   always_comb begin
      w_state_nx       = r_state;
      w_cnt_nx         = r_cnt;
      w_dwell_floor_nx = r_dwell_floor;
      w_clear          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_stop_valid) begin
               w_state_nx       = ST_DWELL;
               w_cnt_nx         = CNT_ONE;
               w_dwell_floor_nx = r_cur_floor;
            end
         end
         ST_DWELL: begin
            if (!w_here) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nx = ST_CLEAR;
            end else begin
               w_cnt_nx = r_cnt + CNT_ONE;
            end
         end
         ST_CLEAR: begin
            w_clear = 1'b1;
            if (w_here) begin
               w_state_nx = ST_HOLD;
            end else begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end
         end
         ST_HOLD: begin
            if (!w_here) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign w_clr = w_clear ? floor_mask(r_dwell_floor) : '0;

   // Request latches: clear the serviced floor, but a same-cycle press wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_up  <= '0;
         r_req_dn  <= '0;
         r_req_cab <= '0;
      end else begin
         r_req_up  <= (r_req_up  & ~w_clr) | w_set_up;
         r_req_dn  <= (r_req_dn  & ~w_clr) | w_set_dn;
         r_req_cab <= (r_req_cab & ~w_clr) | w_set_cab;
      end
   end

   assign req_up       = r_req_up;
   assign req_dn       = r_req_dn;
   assign req_cab      = r_req_cab;
   assign pending      = |{r_req_up, r_req_dn, r_req_cab};
   assign door_hold    = (r_state == ST_DWELL) || (r_state == ST_CLEAR);
   assign sensor_fault = r_sensor_fault;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Bench for elevator_call_latch: directed scenarios plus randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_call_latch;

   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] hall_up_raw, hall_dn_raw, cab_raw, sensor;
   logic       stopped;
   logic [3:0] req_up, req_dn, req_cab;
   logic       pending, door_hold, sensor_fault;

   int checks   = 0;
   int failures = 0;

   elevator_call_latch #(.DWELL(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .hall_up_raw  (hall_up_raw),
      .hall_dn_raw  (hall_dn_raw),
      .cab_raw      (cab_raw),
      .sensor       (sensor),
      .stopped      (stopped),
      .req_up       (req_up),
      .req_dn       (req_dn),
      .req_cab      (req_cab),
      .pending      (pending),
      .door_hold    (door_hold),
      .sensor_fault (sensor_fault)
   );

   always #5 clk = ~clk;

   // Reference model: button sample history, request sets, and a run length of
   // consecutive edges the car has been stopped at one valid floor.
   logic [11:0] m_s1, m_s2, m_s3, m_ev;
   logic [3:0]  m_up, m_dn, m_cab, m_clr;
   logic        m_valid, m_fault, m_here;
   int          m_floor, m_run, m_run_floor;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = '0; m_s2 = '0; m_s3 = '0;
         m_up = '0; m_dn = '0; m_cab = '0;
         m_valid = 1'b0; m_fault = 1'b0; m_floor = 0;
         m_run = 0; m_run_floor = 0;
      end else begin
         // a raw level sampled two edges ago that was low three edges ago is a press now
         m_ev  = m_s2 & ~m_s3;
         m_clr = (m_run == DW + 1) ? (4'b0001 << m_run_floor) : 4'b0000;
         m_up  = (m_up  & ~m_clr) | (m_ev[3:0] & 4'b0111);
         m_dn  = (m_dn  & ~m_clr) | (m_ev[7:4] & 4'b1110);
         m_cab = (m_cab & ~m_clr) | m_ev[11:8];
         m_here = stopped && m_valid && (m_floor == m_run_floor);
         if (m_run > 0 && m_here)  m_run = (m_run < DW + 2) ? m_run + 1 : m_run;
         else if (m_run > 0)       m_run = 0;
         else if (stopped && m_valid) begin m_run = 1; m_run_floor = m_floor; end
         if ($countones(sensor) == 1) begin
            m_valid = 1'b1; m_fault = 1'b0;
            for (int f = 0; f < 4; f++) if (sensor[f]) m_floor = f;
         end else begin
            m_valid = 1'b0; m_fault = ($countones(sensor) > 1);
         end
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = {cab_raw, hall_dn_raw, hall_up_raw};
      end
   end

   function automatic logic [14:0] exp_vec();
      logic dh;
      dh = (m_run >= 1) && (m_run <= DW + 1);
      return {m_up, m_dn, m_cab, |{m_up, m_dn, m_cab}, dh, m_fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; hall_up_raw = '0; hall_dn_raw = '0; cab_raw = '0; sensor = '0; stopped = 1'b0;
      #1;
      checks++;
      if ({req_up, req_dn, req_cab, pending, door_hold, sensor_fault} !== 15'd0) begin
         failures++;
         $display("FAIL reset_state: outputs=%b expected=0", {req_up, req_dn, req_cab, pending, door_hold, sensor_fault});
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({req_up, req_dn, req_cab, pending, door_hold, sensor_fault} !== 15'd0) begin
         failures++;
         $display("FAIL reset_release_idle: outputs=%b expected=0", {req_up, req_dn, req_cab, pending, door_hold, sensor_fault});
      end
   endtask

   task automatic test_masking();
      hall_up_raw = 4'b1000; hall_dn_raw = 4'b0001;
      tick();
      hall_up_raw = '0; hall_dn_raw = '0;
      repeat (4) tick();
      checks++;
      if ({req_up, req_dn, pending} !== 9'd0) begin
         failures++;
         $display("FAIL masking: req_up=%b req_dn=%b pending=%b expected all 0", req_up, req_dn, pending);
      end
   endtask

   task automatic test_single_press();
      cab_raw = 4'b0100;
      tick();                       // edge N samples the press
      cab_raw = '0;
      checks++;
      if (req_cab !== 4'b0000) begin failures++; $display("FAIL press_edge_n: req_cab=%b expected=0000", req_cab); end
      tick();                       // edge N+1
      checks++;
      if (req_cab !== 4'b0000) begin failures++; $display("FAIL press_edge_n1: req_cab=%b expected=0000", req_cab); end
      tick();                       // edge N+2
      checks++;
      if (req_cab !== 4'b0100 || pending !== 1'b1) begin
         failures++;
         $display("FAIL press_edge_n2: req_cab=%b pending=%b expected 0100/1", req_cab, pending);
      end
      cab_raw = 4'b0100;
      repeat (50) tick();
      cab_raw = '0;
      repeat (3) tick();
      checks++;
      if ({req_up, req_dn, req_cab} !== 12'b0000_0000_0100) begin
         failures++;
         $display("FAIL press_hold: req=%b expected=000000000100", {req_up, req_dn, req_cab});
      end
   endtask

   task automatic test_service_clear();
      hall_up_raw = 4'b0010; cab_raw = 4'b1010;
      tick();
      hall_up_raw = '0; cab_raw = '0;
      sensor = 4'b0010;
      repeat (3) tick();
      checks++;
      if (req_up !== 4'b0010 || req_cab !== 4'b1110) begin
         failures++;
         $display("FAIL service_setup: req_up=%b req_cab=%b expected 0010/1110", req_up, req_cab);
      end
      checks++;
      if (door_hold !== 1'b0) begin failures++; $display("FAIL service_pre_dwell: door_hold=%b expected=0", door_hold); end
      stopped = 1'b1;
      for (int i = 0; i <= DW; i++) begin
         tick();
         checks++;
         if (door_hold !== 1'b1 || req_cab !== 4'b1110 || req_up !== 4'b0010) begin
            failures++;
            $display("FAIL service_dwell_%0d: door_hold=%b req_up=%b req_cab=%b expected 1/0010/1110", i, door_hold, req_up, req_cab);
         end
      end
      tick();
      checks++;
      if (req_up !== 4'b0000 || req_cab !== 4'b1100 || door_hold !== 1'b0) begin
         failures++;
         $display("FAIL service_clear: req_up=%b req_cab=%b door_hold=%b expected 0000/1100/0", req_up, req_cab, door_hold);
      end
      repeat (4) tick();
      checks++;
      if (door_hold !== 1'b0 || req_cab !== 4'b1100) begin
         failures++;
         $display("FAIL service_hold: door_hold=%b req_cab=%b expected 0/1100", door_hold, req_cab);
      end
   endtask

   task automatic test_conflict();
      stopped = 1'b0;
      repeat (2) tick();
      cab_raw = 4'b0010; hall_dn_raw = 4'b0010;
      tick();
      cab_raw = '0; hall_dn_raw = '0;
      repeat (3) tick();
      checks++;
      if (req_cab !== 4'b1110 || req_dn !== 4'b0010) begin
         failures++;
         $display("FAIL conflict_setup: req_cab=%b req_dn=%b expected 1110/0010", req_cab, req_dn);
      end
      stopped = 1'b1;
      tick();                       // edge M
      repeat (DW - 2) tick();
      cab_raw = 4'b0010;            // sampled at edge M+DW-1, lands on the clear edge
      tick();
      cab_raw = '0;
      repeat (2) tick();            // through edge M+DW+1
      checks++;
      if (req_cab !== 4'b1110 || req_dn !== 4'b0000 || door_hold !== 1'b0) begin
         failures++;
         $display("FAIL conflict_set_wins: req_cab=%b req_dn=%b door_hold=%b expected 1110/0000/0", req_cab, req_dn, door_hold);
      end
   endtask

   task automatic test_aborted_dwell();
      stopped = 1'b0;
      repeat (2) tick();
      stopped = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (door_hold !== 1'b1) begin failures++; $display("FAIL abort_counting_%0d: door_hold=%b expected=1", i, door_hold); end
      end
      stopped = 1'b0;
      tick();
      checks++;
      if (door_hold !== 1'b0 || req_cab !== 4'b1110) begin
         failures++;
         $display("FAIL abort_no_clear: door_hold=%b req_cab=%b expected 0/1110", door_hold, req_cab);
      end
      repeat (2) tick();
      stopped = 1'b1;
      repeat (DW + 1) tick();
      checks++;
      if (req_cab !== 4'b1110) begin failures++; $display("FAIL abort_redwell_early: req_cab=%b expected=1110", req_cab); end
      tick();
      checks++;
      if (req_cab !== 4'b1100) begin failures++; $display("FAIL abort_redwell_clear: req_cab=%b expected=1100", req_cab); end
      stopped = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_fault();
      sensor = 4'b0101;
      tick();
      checks++;
      if (sensor_fault !== 1'b1) begin failures++; $display("FAIL fault_flag: sensor_fault=%b expected=1", sensor_fault); end
      stopped = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (door_hold !== 1'b0 || sensor_fault !== 1'b1 || req_cab !== 4'b1100) begin
            failures++;
            $display("FAIL fault_no_dwell_%0d: door_hold=%b sensor_fault=%b req_cab=%b expected 0/1/1100", i, door_hold, sensor_fault, req_cab);
         end
      end
      stopped = 1'b0; sensor = 4'b0000;
      tick();
      checks++;
      if (sensor_fault !== 1'b0) begin failures++; $display("FAIL fault_release: sensor_fault=%b expected=0", sensor_fault); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      cab_raw = 4'b0110;
      tick();
      cab_raw = '0;
      repeat (2) tick();
      checks++;
      if (req_cab !== 4'b0110) begin failures++; $display("FAIL reset_mid_setup: req_cab=%b expected=0110", req_cab); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({req_up, req_dn, req_cab, pending, door_hold, sensor_fault} !== 15'd0) begin
         failures++;
         $display("FAIL reset_mid_async: outputs=%b expected=0", {req_up, req_dn, req_cab, pending, door_hold, sensor_fault});
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (5) tick();
      checks++;
      if ({req_up, req_dn, req_cab, pending} !== 13'd0) begin
         failures++;
         $display("FAIL reset_mid_no_ghost: req=%b pending=%b expected 0", {req_up, req_dn, req_cab}, pending);
      end
   endtask

   task automatic test_random();
      logic [14:0] exp, obs;
      int r;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         exp = exp_vec();
         obs = {req_up, req_dn, req_cab, pending, door_hold, sensor_fault};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL random_cycle_%0d: up/dn/cab/pend/door/fault=%b expected=%b", cyc, obs, exp);
         end
         if ($urandom_range(0, 39) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 7)       sensor = 4'b0001 << $urandom_range(0, 3);
            else if (r == 7) sensor = 4'b0000;
            else             sensor = 4'($urandom);
         end
         if ($urandom_range(0, 14) == 0) stopped = ~stopped;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 11) == 0) hall_up_raw[b] = ~hall_up_raw[b];
            if ($urandom_range(0, 11) == 0) hall_dn_raw[b] = ~hall_dn_raw[b];
            if ($urandom_range(0, 11) == 0) cab_raw[b]     = ~cab_raw[b];
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_masking();
      test_single_press();
      test_service_clear();
      test_conflict();
      test_aborted_dwell();
      test_fault();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
